// File: rtl/sprinkler_zone_scheduler.sv
// Shared-pump irrigation controller: latches zone requests, grants them round-robin
// and sequences pump spin-up, watering and settle, gated by GPS fix and debounced rain.
module sprinkler_zone_scheduler #(
   parameter int unsigned NUM_ZONES     = 4,
   parameter int unsigned SPINUP_CYCLES = 4,
   parameter int unsigned WATER_CYCLES  = 16,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned RAIN_DEBOUNCE = 3
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 gps_valid,
   input  logic                 rain_in,
   input  logic [NUM_ZONES-1:0] zone_req,
   output logic [NUM_ZONES-1:0] valve_en,
   output logic                 pump_on,
   output logic [NUM_ZONES-1:0] zone_done,
   output logic                 busy,
   output logic                 rain_hold
);

   localparam int unsigned ZW    = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
   localparam int unsigned MAX_T = (SPINUP_CYCLES > WATER_CYCLES)
                                   ? ((SPINUP_CYCLES > SETTLE_CYCLES) ? SPINUP_CYCLES : SETTLE_CYCLES)
                                   : ((WATER_CYCLES > SETTLE_CYCLES) ? WATER_CYCLES : SETTLE_CYCLES);
   localparam int unsigned CW    = $clog2(MAX_T) + 1;
   localparam int unsigned RW    = $clog2(RAIN_DEBOUNCE) + 1;

   typedef enum logic [1:0] {IDLE, SPINUP, WATER, SETTLE} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ZW-1:0]         grant_q, grant_d;
   logic [ZW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [NUM_ZONES-1:0]  pending_q, pending_d;
   logic [RW-1:0]         rain_cnt_q, rain_cnt_d;
   logic                  rain_hold_q, rain_hold_d;
   logic [NUM_ZONES-1:0]  valve_en_q, valve_en_d;
   logic [NUM_ZONES-1:0]  zone_done_q, zone_done_d;
   logic                  pump_on_q, pump_on_d;
   logic                  busy_q, busy_d;
   logic [NUM_ZONES-1:0]  clr_c;
   logic [ZW-1:0]         grant_c;
   logic                  found_c;
   logic                  permit_c;

   function automatic logic [NUM_ZONES-1:0] zone_bit(input logic [ZW-1:0] z);
      return NUM_ZONES'(1) << z;
   endfunction

   assign permit_c = gps_valid & ~rain_hold_q;

   // Round-robin search: first pending zone at or above rr_ptr, wrapping
   always_comb begin
      grant_c = '0;
      found_c = 1'b0;
      for (int unsigned i = 0; i < NUM_ZONES; i++) begin
         if (!found_c && pending_q[ZW'((32'(rr_ptr_q) + i) % NUM_ZONES)]) begin
            grant_c = ZW'((32'(rr_ptr_q) + i) % NUM_ZONES);
            found_c = 1'b1;
         end
      end
   end

   // Rain debounce: flip only after a full run of disagreeing samples
   always_comb begin
      rain_hold_d = rain_hold_q;
      rain_cnt_d  = '0;
      if (rain_in != rain_hold_q) begin
         if (rain_cnt_q == RW'(RAIN_DEBOUNCE - 1)) begin
            rain_hold_d = ~rain_hold_q;
         end else begin
            rain_cnt_d = rain_cnt_q + RW'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      clr_c       = '0;
      zone_done_d = '0;
      case (state_q)
         IDLE: begin
            if (|pending_q && permit_c) begin
               grant_d = grant_c;
               state_d = SPINUP;
               cnt_d   = '0;
            end
         end
         SPINUP: begin
            if (!permit_c) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(SPINUP_CYCLES - 1)) begin
               state_d = WATER;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WATER: begin
            if (!permit_c) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(WATER_CYCLES - 1)) begin
               state_d     = SETTLE;
               cnt_d       = '0;
               clr_c       = zone_bit(grant_q);
               zone_done_d = zone_bit(grant_q);
               rr_ptr_d    = ZW'((32'(grant_q) + 1) % NUM_ZONES);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
               cnt_d = '0;
               if (|pending_q && permit_c) begin
                  grant_d = grant_c;
                  state_d = WATER;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // New requests win over a same-cycle completion clear
   always_comb begin
      pending_d  = (pending_q & ~clr_c) | zone_req;
      pump_on_d  = (state_d != IDLE);
      busy_d     = (state_d != IDLE);
      valve_en_d = (state_d == WATER) ? zone_bit(grant_d) : '0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         pending_q   <= '0;
         rain_cnt_q  <= '0;
         rain_hold_q <= 1'b0;
         valve_en_q  <= '0;
         zone_done_q <= '0;
         pump_on_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         pending_q   <= pending_d;
         rain_cnt_q  <= rain_cnt_d;
         rain_hold_q <= rain_hold_d;
         valve_en_q  <= valve_en_d;
         zone_done_q <= zone_done_d;
         pump_on_q   <= pump_on_d;
         busy_q      <= busy_d;
      end
   end

   assign valve_en  = valve_en_q;
   assign pump_on   = pump_on_q;
   assign zone_done = zone_done_q;
   assign busy      = busy_q;
   assign rain_hold = rain_hold_q;

endmodule

// File: tb/tb_sprinkler_zone_scheduler.sv
// Scoreboard bench: stimulus queues expected watering sessions and pump runs,
// a negedge monitor reconstructs them from the DUT outputs and compares.
module tb_sprinkler_zone_scheduler;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       gps_valid;
   logic       rain_in;
   logic [3:0] zone_req;
   logic [3:0] valve_en;
   logic       pump_on;
   logic [3:0] zone_done;
   logic       busy;
   logic       rain_hold;

   sprinkler_zone_scheduler #(
      .NUM_ZONES(4), .SPINUP_CYCLES(4), .WATER_CYCLES(16),
      .SETTLE_CYCLES(2), .RAIN_DEBOUNCE(3)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .gps_valid(gps_valid), .rain_in(rain_in),
      .zone_req(zone_req), .valve_en(valve_en), .pump_on(pump_on),
      .zone_done(zone_done), .busy(busy), .rain_hold(rain_hold)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] valve;
      int         len;
      int         lead;
      logic [3:0] done;
   } water_t;

   water_t exp_w[$];
   int     exp_pump[$];
   int     n_cmp = 0;
   int     n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse(input logic [3:0] v);
      zone_req = v;
      cyc(1);
      zone_req = 4'b0000;
   endtask

   task automatic wait_valve(input logic [3:0] v, input int budget);
      int k = 0;
      while (valve_en !== v && k < budget) begin
         @(negedge CLK);
         k++;
      end
      if (valve_en !== v) check("wait_valve_timeout", 32'(valve_en), 32'(v));
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((busy !== 1'b0 || pump_on !== 1'b0) && k < budget) begin
         @(negedge CLK);
         k++;
      end
      if (busy !== 1'b0 || pump_on !== 1'b0) check("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   // Monitor: rebuild sessions (valve, open length, spin/settle lead, done) and pump runs
   initial begin
      logic [3:0] prev_valve, cur_valve;
      int         vlen, lead, open_lead, plen;
      logic       ok;
      water_t     got, e;
      prev_valve = '0; cur_valve = '0; vlen = 0; lead = 0; open_lead = 0; plen = 0;
      forever begin
         @(negedge CLK);
         if (RST_N !== 1'b1) begin
            prev_valve = '0; vlen = 0; lead = 0; plen = 0;
         end else begin
            ok = $onehot0(valve_en) && (busy === pump_on) && !(valve_en != 0 && !pump_on)
                 && !(zone_done != 0 && !(valve_en == 0 && prev_valve != 0))
                 && !(valve_en != 0 && prev_valve != 0 && valve_en != cur_valve);
            n_cmp++;
            if (!ok) begin
               n_bad++;
               $display("FAIL cycle_invariant: valve=%b pump=%b busy=%b done=%b prev=%b at %0t",
                        valve_en, pump_on, busy, zone_done, prev_valve, $time);
            end
            if (valve_en != 0) begin
               if (prev_valve == 0) begin
                  cur_valve = valve_en; vlen = 1; open_lead = lead;
               end else begin
                  vlen++;
               end
               lead = 0;
            end else begin
               if (prev_valve != 0) begin
                  got = '{cur_valve, vlen, open_lead, zone_done};
                  n_cmp++;
                  if (exp_w.size() == 0) begin
                     n_bad++;
                     $display("FAIL water_unexpected: got valve=%b len=%0d lead=%0d done=%b",
                              got.valve, got.len, got.lead, got.done);
                  end else begin
                     e = exp_w.pop_front();
                     if (got.valve !== e.valve || got.len != e.len || got.lead != e.lead
                         || got.done !== e.done) begin
                        n_bad++;
                        $display("FAIL water_session: got valve=%b len=%0d lead=%0d done=%b expected valve=%b len=%0d lead=%0d done=%b",
                                 got.valve, got.len, got.lead, got.done, e.valve, e.len, e.lead, e.done);
                     end
                  end
               end
               lead = pump_on ? lead + 1 : 0;
            end
            if (pump_on) begin
               plen++;
            end else if (plen > 0) begin
               n_cmp++;
               if (exp_pump.size() == 0) begin
                  n_bad++;
                  $display("FAIL pump_unexpected: got run of %0d cycles", plen);
               end else begin
                  int ep;
                  ep = exp_pump.pop_front();
                  if (plen != ep) begin
                     n_bad++;
                     $display("FAIL pump_run: got %0d cycles expected %0d", plen, ep);
                  end
               end
               plen = 0;
            end
            prev_valve = valve_en;
         end
      end
   end

   initial begin
      RST_N = 1'b0; gps_valid = 1'b1; rain_in = 1'b0; zone_req = 4'b1111;
      cyc(3);
      check("reset_valve", 32'(valve_en), 32'd0);
      check("reset_pump", 32'(pump_on), 32'd0);
      check("reset_done", 32'(zone_done), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_rain_hold", 32'(rain_hold), 32'd0);

      // All four zones requested across release: one spin-up, 0..3 in order
      exp_w.push_back('{4'b0001, 16, 4, 4'b0001});
      exp_w.push_back('{4'b0010, 16, 2, 4'b0010});
      exp_w.push_back('{4'b0100, 16, 2, 4'b0100});
      exp_w.push_back('{4'b1000, 16, 2, 4'b1000});
      exp_pump.push_back(4 + 4*16 + 4*2);
      RST_N = 1'b1;
      pulse(4'b1111);
      cyc(3);
      wait_idle(200);
      cyc(2);

      // Round robin 1011 from rr_ptr 0
      exp_w.push_back('{4'b0001, 16, 4, 4'b0001});
      exp_w.push_back('{4'b0010, 16, 2, 4'b0010});
      exp_w.push_back('{4'b1000, 16, 2, 4'b1000});
      exp_pump.push_back(58);
      pulse(4'b1011);
      cyc(3);
      wait_idle(200);
      cyc(2);

      // Single request
      exp_w.push_back('{4'b0100, 16, 4, 4'b0100});
      exp_pump.push_back(22);
      pulse(4'b0100);
      cyc(3);
      wait_idle(100);
      cyc(2);

      // Rain abort on zone 1 from WATER cycle 5
      exp_w.push_back('{4'b0010, 8, 4, 4'b0000});
      exp_pump.push_back(14);
      pulse(4'b0010);
      wait_valve(4'b0010, 20);
      cyc(4);
      rain_in = 1'b1;
      wait_idle(50);
      check("rain_hold_set", 32'(rain_hold), 32'd1);
      cyc(5);
      check("idle_while_raining", 32'(busy), 32'd0);
      exp_w.push_back('{4'b0010, 16, 4, 4'b0010});
      exp_pump.push_back(22);
      rain_in = 1'b0;
      cyc(3);
      check("rain_hold_clear", 32'(rain_hold), 32'd0);
      check("no_start_before_clear", 32'(busy), 32'd0);
      cyc(2);
      wait_idle(100);
      cyc(2);

      // Two-cycle rain glitch must not interrupt zone 0
      exp_w.push_back('{4'b0001, 16, 4, 4'b0001});
      exp_pump.push_back(22);
      pulse(4'b0001);
      wait_valve(4'b0001, 20);
      rain_in = 1'b1;
      cyc(2);
      rain_in = 1'b0;
      check("glitch_rain_hold", 32'(rain_hold), 32'd0);
      check("glitch_valve", 32'(valve_en), 32'b0001);
      wait_idle(100);
      cyc(2);

      // No GPS fix: request held pending, served once fix returns
      gps_valid = 1'b0;
      pulse(4'b0001);
      cyc(10);
      check("idle_no_gps", 32'(busy), 32'd0);
      exp_w.push_back('{4'b0001, 16, 4, 4'b0001});
      exp_pump.push_back(22);
      gps_valid = 1'b1;
      cyc(3);
      wait_idle(100);
      cyc(2);

      // Reset mid-WATER on zone 2: asynchronous drop, request lost
      pulse(4'b0100);
      wait_valve(4'b0100, 20);
      cyc(3);
      #2 RST_N = 1'b0;
      #1;
      check("async_valve", 32'(valve_en), 32'd0);
      check("async_pump", 32'(pump_on), 32'd0);
      cyc(2);
      RST_N = 1'b1;
      cyc(10);
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_valve", 32'(valve_en), 32'd0);

      cyc(3);
      check("water_queue_drained", 32'(exp_w.size()), 32'd0);
      check("pump_queue_drained", 32'(exp_pump.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
